// File: rtl/issue_scoreboard_ctrl.sv
// Issue controller for the 8-bit core. It tracks pending register writes, stalls on RAW hazards
// and in-flight limits, and drains the pipeline when a flush is requested.
module issue_scoreboard_ctrl #(
    parameter int unsigned MAX_PEND = 3,
    parameter int unsigned MAX_OUT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instruction_input,
    output logic        instr_ready,
    output logic        issue_valid,
    output logic [15:0] instruction_output,
    input  logic        regwrite,
    input  logic [2:0]  write_addr,
    input  logic        retire,
    input  logic        flush_req,
    output logic        flush_done,
    output logic        sb_err,
    output logic [15:0] stall_cnt
);

    localparam int unsigned PW = $clog2(MAX_PEND + 1);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StDrain = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pend_q [8];
    logic [PW-1:0] pend_d [8];
    logic [OW-1:0] out_cnt_q, out_cnt_d;
    logic          issue_valid_q;
    logic [15:0]   instr_out_q;
    logic          sb_err_q, sb_err_d;
    logic [15:0]   stall_cnt_q, stall_cnt_d;

    logic [4:0] opcode;
    logic [2:0] rd, rs;
    logic       rd_read, rs_read, rd_write;
    logic       hazard, pend_full, all_clear, issue;

    assign opcode = instruction_input[15:11];
    assign rd     = instruction_input[10:8];
    assign rs     = instruction_input[7:5];

    always_comb begin
        rd_read  = 1'b0;
        rs_read  = 1'b0;
        rd_write = 1'b0;
        unique case (opcode)
            5'b01100, 5'b01101: rd_write = 1'b1;
            5'b01110:           rd_read  = 1'b1;
            5'b01000, 5'b01001, 5'b01010, 5'b01011,
            5'b11100, 5'b11101, 5'b11110: begin
                rd_read  = 1'b1;
                rd_write = 1'b1;
            end
            5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110: begin
                rd_read  = 1'b1;
                rs_read  = 1'b1;
                rd_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Hazards use registered pending counts only; a same-cycle writeback is not bypassed.
    assign hazard    = (rd_read && pend_q[rd] != '0) || (rs_read && pend_q[rs] != '0);
    assign pend_full = rd_write && (pend_q[rd] >= PW'(MAX_PEND));

    always_comb begin
        all_clear = (out_cnt_q == '0);
        for (int i = 0; i < 8; i++) begin
            if (pend_q[i] != '0) all_clear = 1'b0;
        end
    end

    assign instr_ready = (state_q == StRun) && !flush_req && !hazard && !pend_full &&
                         (out_cnt_q < OW'(MAX_OUT));
    assign issue       = instr_valid && instr_ready;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pend_d[i] = pend_q[i];
            if (issue && rd_write && rd == 3'(i)) begin
                if (!(regwrite && write_addr == 3'(i))) pend_d[i] = pend_q[i] + 1'b1;
            end else if (regwrite && write_addr == 3'(i) && pend_q[i] != '0) begin
                pend_d[i] = pend_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (issue && !(retire && out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!issue && retire && out_cnt_q != '0) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_comb begin
        sb_err_d = sb_err_q;
        if (regwrite && pend_q[write_addr] == '0) sb_err_d = 1'b1;
        stall_cnt_d = stall_cnt_q;
        if (instr_valid && !instr_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   if (flush_req) state_d = StDrain;
            StDrain: if (all_clear) state_d = StDone;
            StDone:  state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            out_cnt_q     <= '0;
            issue_valid_q <= 1'b0;
            instr_out_q   <= 16'h0000;
            sb_err_q      <= 1'b0;
            stall_cnt_q   <= 16'h0000;
            for (int i = 0; i < 8; i++) pend_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            out_cnt_q     <= out_cnt_d;
            issue_valid_q <= issue;
            if (issue) instr_out_q <= instruction_input;
            sb_err_q      <= sb_err_d;
            stall_cnt_q   <= stall_cnt_d;
            for (int i = 0; i < 8; i++) pend_q[i] <= pend_d[i];
        end
    end

    assign issue_valid        = issue_valid_q;
    assign instruction_output = instr_out_q;
    assign flush_done         = (state_q == StDone);
    assign sb_err             = sb_err_q;
    assign stall_cnt          = stall_cnt_q;

endmodule

// File: doc/issue_scoreboard_ctrl.md
Name: issue_scoreboard_ctrl

Overview:
- Issue controller between instruction fetch and the id stage of the 8-bit core.
- Decodes each 16-bit instruction's register reads/writes and keeps a per-register pending-write scoreboard that clears on writeback.
- Stalls issue on RAW hazards or resource limits, and provides a drain/flush sequence so the pipeline can empty before a reset or redirect.

Parameters:
- MAX_PEND, 3: max outstanding writes per register (counter width 2 bits).
- MAX_OUT, 4: max total instructions in flight past issue (counter width 3 bits).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  fetch presents instruction_input.
- instruction_input  input  16  [15:11] opcode, [10:8] rd, [7:5] rs.
- instr_ready  output  1  controller accepts this cycle (combinational).
- issue_valid  output  1  registered; issued instruction valid to id.
- instruction_output  output  16  registered copy of the issued instruction.
- regwrite  input  1  writeback retire strobe (reg-writing instruction).
- write_addr  input  3  register retired by writeback.
- retire  input  1  any instruction leaves pipeline (1 per cycle max; includes non-writers).
- flush_req  input  1  pulse: stop issuing and drain.
- flush_done  output  1  one-cycle pulse when drain completes.
- sb_err  output  1  sticky: regwrite retired a register with zero pending count.
- stall_cnt  output  16  saturating count of cycles with instr_valid & !instr_ready.

Behaviour:
- Decode (combinational):
  - LDI 01100, LDD 01101: read none, write rd.
  - STD 01110: read rd field, write none.
  - ADDI/SUBI/ANDI/ORI 01000-01011: read rd, write rd.
  - NOT/SHL/SHR 11100-11110: read rd, write rd.
  - ADD/SUB/AND/OR/EOR 10000,10001,10010,10011,10110: read rd and rs, write rd.
  - Any other opcode: NOP, no reads, no writes; still counts toward MAX_OUT.
- FSM states RUN, DRAIN, DONE; reset goes to RUN.
- instr_ready = state==RUN & no read reg has pend[r]!=0 & (no write or pend[rd]<MAX_PEND) & out_cnt<MAX_OUT. Pending counts are the current registered values; same-cycle retire is not bypassed.
- Issue = instr_valid & instr_ready. Next cycle: issue_valid=1 and instruction_output=instruction_input. Otherwise issue_valid=0 and instruction_output holds its value.
- pend[rd] +1 on issue of a writer, -1 on regwrite to write_addr. Both to the same reg in one cycle: unchanged.
- regwrite when pend[write_addr]==0: count stays 0, sb_err set until rst.
- out_cnt +1 on issue, -1 on retire, unchanged when both occur. retire at out_cnt==0 is ignored.
- RUN -> DRAIN on flush_req. Issue in the flush_req cycle itself is blocked.
- DRAIN -> DONE when out_cnt==0 and all pend==0, evaluated on registered values.
- DONE: flush_done=1 for one cycle, then -> RUN.
- flush_req in DRAIN or DONE is ignored.
- stall_cnt increments when instr_valid & !instr_ready in any state, saturates at 16'hFFFF.
- Reset: all pend=0, out_cnt=0, state RUN, issue_valid=0, instruction_output=16'h0000, flush_done=0, sb_err=0, stall_cnt=0.
- rst mid-DRAIN returns to RUN with no flush_done pulse.

Test Plan:
- Reset, then LDI 16'b01100_001_00110011 -> issue_valid=1 next cycle, instruction_output matches, pend[1]=1. The following ADD 16'b10000_010_001_00000 stalls (instr_ready=0) until regwrite=1, write_addr=3'b001. It issues the cycle after that retire; stall_cnt equals the stalled cycles.
- LDI X[3], then STD 16'b01110_010_00000010 with X[2] idle -> STD issues back-to-back, no stall. STD does not change any pend count.
- Issue 4 independent LDIs to X[1]..X[4] with no retire -> the 5th instruction stalls on out_cnt=4. One retire -> it issues next cycle.
- Same cycle: issue LDI X[5] while regwrite retires X[5] with pend[5]=1 -> pend[5] stays 1. Retire X[6] with pend[6]=0 -> sb_err=1 and stays set until rst.
- flush_req with 2 in flight -> instr_ready=0 throughout. After the 2nd retire (with regwrites clearing pend), flush_done pulses exactly 1 cycle, then issue resumes.
- rst asserted while in DRAIN -> next cycle state RUN, all outputs at reset values, no flush_done pulse.
